// File: rtl/sim_jtag_pkg.sv
// Shared types and constants for the simulated JTAG IDCODE reader.
// Holds the sequencer state enum, the exit codes and the per-state bit-count limits.
package sim_jtag_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StTrst,
    StTlr,
    StToShiftIr,
    StShiftIr,
    StToShiftDr,
    StShiftDr,
    StToIdle,
    StDone
  } state_e;

  localparam logic [31:0] EXIT_RUN  = 32'd0;
  localparam logic [31:0] EXIT_PASS = 32'd1;
  localparam logic [31:0] EXIT_FAIL = 32'd2;

  localparam int unsigned BitCntW = 8;

  // Index of the final bit in each fixed-length state.
  localparam logic [BitCntW-1:0] TrstLast      = 8'd1;
  localparam logic [BitCntW-1:0] TlrLast       = 8'd6;
  localparam logic [BitCntW-1:0] ToShiftIrLast = 8'd3;
  localparam logic [BitCntW-1:0] ToShiftDrLast = 8'd2;
  localparam logic [BitCntW-1:0] ShiftDrLast   = 8'd31;
  localparam logic [BitCntW-1:0] ToIdleLast    = 8'd1;

endpackage

// File: rtl/sim_jtag_tick_gen.sv
// Half-bit tick generator for the JTAG sequencer.
// Ports:
//   clk_i   system clock
//   rst_i   synchronous active-high reset
//   en_i    advance permission; when low the counter holds
//   tick_o  one-cycle pulse when the counter wraps from TICK_DELAY-1 to 0
module sim_jtag_tick_gen #(
  parameter int unsigned TICK_DELAY = 50
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tick_o
);

  // A delay of 0 is treated as 1 so the sequencer can never lock up.
  localparam int unsigned Delay = (TICK_DELAY < 1) ? 1 : TICK_DELAY;
  localparam int unsigned CntW  = (Delay > 1) ? $clog2(Delay) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Delay - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = en_i && (cnt_q == CntMax);
    cnt_d  = cnt_q;
    if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sim_jtag.sv
// Simulation-side JTAG master: resets the TAP, loads the IDCODE instruction,
// shifts out the 32-bit IDCODE and reports whether it matches EXPECTED_IDCODE.
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   enable, init_done   both high to let the sequence advance; otherwise everything holds
//   jtag_TCK/TMS/TDI    JTAG drive to the target
//   jtag_TRSTn          active-low TAP reset
//   srstn               active-low system reset, tied inactive
//   jtag_TDO_data       TDO from target
//   jtag_TDO_driven     TDO valid; an undriven TDO reads as 1
//   exit                0 running, 1 IDCODE matched, 2 IDCODE mismatch
module sim_jtag
  import sim_jtag_pkg::*;
#(
  parameter int unsigned        TICK_DELAY      = 50,
  parameter int unsigned        IR_LEN          = 5,
  parameter logic [IR_LEN-1:0]  IDCODE_INSTR    = 'h01,
  parameter logic [31:0]        EXPECTED_IDCODE = 32'h249511C3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        init_done,
  output logic        jtag_TCK,
  output logic        jtag_TMS,
  output logic        jtag_TDI,
  output logic        jtag_TRSTn,
  output logic        srstn,
  input  logic        jtag_TDO_data,
  input  logic        jtag_TDO_driven,
  output logic [31:0] exit
);

  localparam logic [BitCntW-1:0] IrLast      = BitCntW'(IR_LEN - 1);
  // Shift-IR is followed by two extra bits: Exit1 -> Update-IR, then -> Run-Test/Idle.
  localparam logic [BitCntW-1:0] ShiftIrLast = BitCntW'(IR_LEN + 1);

  state_e               state_q, state_d, state_nxt;
  logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d, last_bit;
  logic                 phase_q, phase_d;  // 0: next tick is A (TCK low), 1: tick B (TCK high)
  logic                 tick;

  logic                 tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d, trstn_q, trstn_d;
  logic [31:0]          exit_q, exit_d, capture_q, capture_d;
  logic                 tms_bit, tdi_bit, tdo_sample;
  logic [IR_LEN-1:0]    ir_shifted;

  sim_jtag_tick_gen #(
    .TICK_DELAY(TICK_DELAY)
  ) u_tick_gen (
    .clk_i  (clock),
    .rst_i  (reset),
    .en_i   (enable & init_done),
    .tick_o (tick)
  );

  assign tdo_sample = jtag_TDO_driven ? jtag_TDO_data : 1'b1;

  // Per-state bit length, successor and the TMS/TDI value for the current bit.
  always_comb begin
    last_bit   = '0;
    state_nxt  = state_q;
    tms_bit    = 1'b0;
    tdi_bit    = 1'b0;
    ir_shifted = IDCODE_INSTR >> bit_cnt_q;
    case (state_q)
      StTrst: begin
        last_bit  = TrstLast;
        state_nxt = StTlr;
        tms_bit   = 1'b1;
      end
      StTlr: begin
        last_bit  = TlrLast;
        state_nxt = StToShiftIr;
        tms_bit   = (bit_cnt_q != TlrLast);
      end
      StToShiftIr: begin
        last_bit  = ToShiftIrLast;
        state_nxt = StShiftIr;
        tms_bit   = (bit_cnt_q <= BitCntW'(1));
      end
      StShiftIr: begin
        last_bit  = ShiftIrLast;
        state_nxt = StToShiftDr;
        if (bit_cnt_q <= IrLast) begin
          tdi_bit = ir_shifted[0];
          tms_bit = (bit_cnt_q == IrLast);
        end else begin
          tms_bit = (bit_cnt_q != ShiftIrLast);
        end
      end
      StToShiftDr: begin
        last_bit  = ToShiftDrLast;
        state_nxt = StShiftDr;
        tms_bit   = (bit_cnt_q == '0);
      end
      StShiftDr: begin
        last_bit  = ShiftDrLast;
        state_nxt = StToIdle;
        tms_bit   = (bit_cnt_q == ShiftDrLast);
      end
      StToIdle: begin
        last_bit  = ToIdleLast;
        state_nxt = StDone;
        tms_bit   = (bit_cnt_q == '0);
      end
      default: ;
    endcase
  end

  // Next-state logic: everything moves only on a tick.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    phase_d   = phase_q;
    if (tick) begin
      case (state_q)
        StIdle: begin
          state_d   = StTrst;
          bit_cnt_d = '0;
          phase_d   = 1'b0;
        end
        StDone: ;
        default: begin
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (bit_cnt_q == last_bit) begin
              bit_cnt_d = '0;
              state_d   = state_nxt;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Output and capture next values.
  always_comb begin
    tck_d     = tck_q;
    tms_d     = tms_q;
    tdi_d     = tdi_q;
    trstn_d   = trstn_q;
    exit_d    = exit_q;
    capture_d = capture_q;
    if (tick) begin
      case (state_q)
        StIdle: begin
          // TRSTn drops here so it stays low for exactly the four TRST ticks.
          trstn_d = 1'b0;
          tck_d   = 1'b0;
        end
        StTrst: begin
          tck_d = 1'b0;
          if (phase_q && (bit_cnt_q == TrstLast)) begin
            trstn_d = 1'b1;
          end
        end
        StDone: begin
          tck_d = 1'b0;
          tms_d = 1'b0;
          tdi_d = 1'b0;
        end
        default: begin
          if (!phase_q) begin
            tck_d = 1'b0;
            tms_d = tms_bit;
            tdi_d = tdi_bit;
          end else begin
            tck_d = 1'b1;
            if (state_q == StShiftDr) begin
              capture_d = {tdo_sample, capture_q[31:1]};
            end
            // Result registers on the final tick so it is visible the cycle after.
            if ((state_q == StToIdle) && (bit_cnt_q == ToIdleLast)) begin
              exit_d = (capture_q == EXPECTED_IDCODE) ? EXIT_PASS : EXIT_FAIL;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      phase_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      phase_q   <= phase_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tck_q     <= 1'b0;
      tms_q     <= 1'b1;
      tdi_q     <= 1'b0;
      trstn_q   <= 1'b1;
      exit_q    <= EXIT_RUN;
      capture_q <= '0;
    end else begin
      tck_q     <= tck_d;
      tms_q     <= tms_d;
      tdi_q     <= tdi_d;
      trstn_q   <= trstn_d;
      exit_q    <= exit_d;
      capture_q <= capture_d;
    end
  end

  assign jtag_TCK   = tck_q;
  assign jtag_TMS   = tms_q;
  assign jtag_TDI   = tdi_q;
  assign jtag_TRSTn = trstn_q;
  assign srstn      = 1'b1;
  assign exit       = exit_q;

endmodule

// File: tb/tb_sim_jtag.sv
// Bench for sim_jtag: u_dut1 (TICK_DELAY=1) talks to a behavioural TAP,
// u_dut4 (TICK_DELAY=4) runs with TDO undriven and has its TMS stream and TCK spacing checked.
module tb_sim_jtag;

  localparam logic [31:0] Good = 32'h249511C3;

  localparam logic [3:0] TapTlr = 4'd0, TapRti = 4'd1, TapSelDr = 4'd2, TapCapDr = 4'd3,
                         TapShDr = 4'd4, TapEx1Dr = 4'd5, TapPaDr = 4'd6, TapEx2Dr = 4'd7,
                         TapUpDr = 4'd8, TapSelIr = 4'd9, TapCapIr = 4'd10, TapShIr = 4'd11,
                         TapEx1Ir = 4'd12, TapPaIr = 4'd13, TapEx2Ir = 4'd14, TapUpIr = 4'd15;

  typedef struct {
    logic [31:0] exit_v;
    logic [31:0] cap;
    int          edges;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en1, init1, en4, init4;
  logic        tck1, tms1, tdi1, trstn1, srstn1, tdo1, drv1;
  logic        tck4, tms4, tdi4, trstn4, srstn4, tdo4, drv4;
  logic [31:0] exit1, exit4;

  assign tdo4 = 1'b0;
  assign drv4 = 1'b0;

  sim_jtag #(.TICK_DELAY(1)) u_dut1 (
    .clock(clk), .reset(rst), .enable(en1), .init_done(init1),
    .jtag_TCK(tck1), .jtag_TMS(tms1), .jtag_TDI(tdi1), .jtag_TRSTn(trstn1), .srstn(srstn1),
    .jtag_TDO_data(tdo1), .jtag_TDO_driven(drv1), .exit(exit1)
  );

  sim_jtag #(.TICK_DELAY(4)) u_dut4 (
    .clock(clk), .reset(rst), .enable(en4), .init_done(init4),
    .jtag_TCK(tck4), .jtag_TMS(tms4), .jtag_TDI(tdi4), .jtag_TRSTn(trstn4), .srstn(srstn4),
    .jtag_TDO_data(tdo4), .jtag_TDO_driven(drv4), .exit(exit4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural TAP on u_dut1 ----------------
  logic [3:0]  tap_st = TapTlr;
  logic [4:0]  tap_ir = 5'h1f, tap_irsh = 5'h00;
  logic [31:0] tap_dr = '0;
  logic [31:0] tap_idcode = Good;
  logic        drv_cfg = 1'b1;

  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic tms);
    case (s)
      TapTlr:   return tms ? TapTlr   : TapRti;
      TapRti:   return tms ? TapSelDr : TapRti;
      TapSelDr: return tms ? TapSelIr : TapCapDr;
      TapCapDr: return tms ? TapEx1Dr : TapShDr;
      TapShDr:  return tms ? TapEx1Dr : TapShDr;
      TapEx1Dr: return tms ? TapUpDr  : TapPaDr;
      TapPaDr:  return tms ? TapEx2Dr : TapPaDr;
      TapEx2Dr: return tms ? TapUpDr  : TapShDr;
      TapUpDr:  return tms ? TapSelDr : TapRti;
      TapSelIr: return tms ? TapTlr   : TapCapIr;
      TapCapIr: return tms ? TapEx1Ir : TapShIr;
      TapShIr:  return tms ? TapEx1Ir : TapShIr;
      TapEx1Ir: return tms ? TapUpIr  : TapPaIr;
      TapPaIr:  return tms ? TapEx2Ir : TapPaIr;
      TapEx2Ir: return tms ? TapUpIr  : TapShIr;
      default:  return tms ? TapSelDr : TapRti;
    endcase
  endfunction

  // Reset IR is BYPASS (not IDCODE) so a wrong IR shift shows up as a zero capture.
  always @(posedge tck1 or negedge trstn1) begin
    if (!trstn1) begin
      tap_st <= TapTlr;
      tap_ir <= 5'h1f;
    end else begin
      case (tap_st)
        TapTlr:   tap_ir   <= 5'h1f;
        TapCapDr: tap_dr   <= (tap_ir == 5'h01) ? tap_idcode : 32'h0;
        TapShDr:  tap_dr   <= {tdi1, tap_dr[31:1]};
        TapCapIr: tap_irsh <= 5'b00001;
        TapShIr:  tap_irsh <= {tdi1, tap_irsh[4:1]};
        TapUpIr:  tap_ir   <= tap_irsh;
        default: ;
      endcase
      tap_st <= tap_next(tap_st, tms1);
    end
  end

  // Outside Shift-DR the TAP drives 0 while still claiming valid.
  assign tdo1 = (tap_st == TapShDr) ? tap_dr[0] : 1'b0;
  assign drv1 = drv_cfg;

  // ---------------- monitors ----------------
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic tck1_prev = 1'b0, tck4_prev = 1'b0;
  int   rises1 = 0, rises4 = 0, last_edge4 = -1, bad_space4 = 0;
  logic tms_exp_q[$];
  exp_t sb_q[$];

  always @(negedge clk) begin
    logic e;
    tck1_prev <= tck1;
    if (tck1 && !tck1_prev) rises1 <= rises1 + 1;
    tck4_prev <= tck4;
    if (tck4 !== tck4_prev) begin
      if (last_edge4 >= 0 && (cyc - last_edge4) != 4) bad_space4 <= bad_space4 + 1;
      last_edge4 <= cyc;
    end
    if (tck4 && !tck4_prev) begin
      rises4 <= rises4 + 1;
      e = (tms_exp_q.size() != 0) ? tms_exp_q.pop_front() : 1'bx;
      check_eq("td4_tms_bit", {31'b0, tms4}, {31'b0, e});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    en1 = 1'b0;
    en4 = 1'b0;
    init1 = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_tms(input logic [63:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) tms_exp_q.push_back(bits[i]);
  endtask

  task automatic start_run1(input logic [31:0] idc, input logic drv, input logic [31:0] ex,
                            input logic [31:0] cap, output int base);
    do_reset();
    tap_idcode = idc;
    drv_cfg    = drv;
    sb_q.push_back('{ex, cap, 55});
    base = rises1;
    en1  = 1'b1;
  endtask

  task automatic wait_rises1(input string tag, input int n);
    int k = 0;
    while (rises1 < n && k < 500) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_reached"}, {31'b0, rises1 >= n}, 32'd1);
  endtask

  task automatic wait_result(input string tag, input bit use4, input int budget, input int base,
                             output int elapsed);
    logic [31:0] ex;
    exp_t        e;
    int          n = 0;
    ex = use4 ? exit4 : exit1;
    while (ex == 32'd0 && n < budget) begin
      @(negedge clk);
      n++;
      ex = use4 ? exit4 : exit1;
    end
    elapsed = n;
    check_eq({tag, "_done"}, {31'b0, ex != 32'd0}, 32'd1);
    @(negedge clk);  // let the rise counter settle
    if (sb_q.size() != 0) e = sb_q.pop_front();
    else begin
      e.exit_v = 'x;
      e.cap    = 'x;
      e.edges  = -1;
    end
    check_eq({tag, "_exit"}, ex, e.exit_v);
    check_eq({tag, "_capture"}, use4 ? u_dut4.capture_q : u_dut1.capture_q, e.cap);
    check_eq({tag, "_tck_rises"}, (use4 ? rises4 : rises1) - base, e.edges);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int          base, el, changes;
    logic [36:0] snap;
    rst = 1'b1; en1 = 1'b0; en4 = 1'b0; init1 = 1'b1; init4 = 1'b1;
    repeat (3) @(negedge clk);

    // reset state: TCK,TMS,TDI,TRSTn,srstn = 0,1,0,1,1
    check_eq("rst_pins", {27'b0, tck1, tms1, tdi1, trstn1, srstn1}, 32'b01011);
    check_eq("rst_exit", exit1, 32'd0);
    check_eq("rst_capture", u_dut1.capture_q, 32'd0);
    rst = 1'b0;

    start_run1(Good, 1'b1, 32'd1, Good, base);
    wait_result("pass", 1'b0, 200, base, el);
    check_eq("pass_within_120", {31'b0, el <= 120}, 32'd1);

    start_run1(32'hDEADBEEF, 1'b1, 32'd2, 32'hDEADBEEF, base);
    wait_result("mismatch", 1'b0, 200, base, el);

    start_run1(Good, 1'b0, 32'd2, 32'hFFFFFFFF, base);
    wait_result("undriven", 1'b0, 200, base, el);

    // init_done dropped for 40 cycles inside SHIFT_DR
    start_run1(Good, 1'b1, 32'd1, Good, base);
    wait_rises1("stall", base + 30);
    snap = {tck1, tms1, tdi1, trstn1, srstn1, exit1};
    init1 = 1'b0;
    changes = 0;
    repeat (40) begin
      @(negedge clk);
      if ({tck1, tms1, tdi1, trstn1, srstn1, exit1} !== snap) changes++;
    end
    check_eq("stall_frozen_changes", changes, 32'd0);
    init1 = 1'b1;
    wait_result("stall", 1'b0, 200, base, el);

    // reset pulse during SHIFT_IR, then a clean rerun
    do_reset();
    tap_idcode = Good;
    drv_cfg    = 1'b1;
    en1        = 1'b1;
    wait_rises1("midrst", rises1 + 13);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_tck_tms_trstn", {29'b0, tck1, tms1, trstn1}, 32'b011);
    check_eq("midrst_exit", exit1, 32'd0);
    rst = 1'b0;
    sb_q.push_back('{32'd1, Good, 55});
    base = rises1;
    wait_result("rerun", 1'b0, 200, base, el);

    // TICK_DELAY=4 instance, TDO never driven
    do_reset();
    push_tms(64'b1111110, 7);
    push_tms(64'b1100, 4);
    push_tms(64'b0000110, 7);
    push_tms(64'b100, 3);
    push_tms(64'h1, 32);
    push_tms(64'b10, 2);
    sb_q.push_back('{32'd2, 32'hFFFFFFFF, 55});
    base = rises4;
    en4  = 1'b1;
    wait_result("td4", 1'b1, 700, base, el);
    repeat (8) @(negedge clk);
    check_eq("td4_bad_spacing", bad_space4, 32'd0);
    check_eq("td4_tms_left", tms_exp_q.size(), 32'd0);
    check_eq("srstn_both", {30'b0, srstn1, srstn4}, 32'b11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
